block_raster_axi_reader: RTL and testbench
==========================================

// Module: block_raster_axi_reader
// PURPOSE
//  AXI4 read master fetching a frame in BLOCK_H x BLOCK_W tiles: one INCR burst per tile line, raster order.
//  Streams pixels with tile/frame markers under valid/ready backpressure.
//  Generalised successor to the noise-estimation reader; feeds noise estimation and Wiener stages.
// PARAMETERS
//  ADDR_WIDTH  32  AXI address width
//  DATA_WIDTH  32  pixel/beat width; bytes per pixel BPP = DATA_WIDTH/8
//  BLOCK_W     8   tile width in pixels = beats per burst (<=256)
//  BLOCK_H     8   tile height in lines = bursts per tile
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           reset, asynchronous, active-low
//  frame_width    in   16          pixels per line, latched at frame_start
//  frame_height   in   16          lines per frame, latched at frame_start
//  base_addr      in   ADDR_WIDTH  frame byte base, latched at frame_start
//  frame_start    in   1           start request, honoured only in IDLE
//  consumer_done  in   1           downstream finished frame; releases WAIT_DONE
//  arvalid/arready  out/in  1      AXI AR handshake
//  araddr         out  ADDR_WIDTH  burst start address
//  arlen/arsize/arburst out 8/3/2  BLOCK_W-1 / log2(BPP) / 2'b01 INCR, constant
//  rvalid/rready  in/out  1        AXI R handshake
//  rdata          in   DATA_WIDTH  read beat
//  rlast          in   1           last beat of burst
//  rresp          in   2           response; nonzero = error
//  out_valid/out_ready out/in 1    pixel stream handshake
//  out_data       out  DATA_WIDTH  pixel
//  out_sof/out_sob/out_eob/out_eof out 1  first pixel of frame / of tile, last of tile / of frame
//  blk_row/blk_col out 16          tile coordinates of out_data
//  busy           out  1           state != IDLE
//  frame_done     out  1           one-cycle pulse on WAIT_DONE -> IDLE
//  err            out  1           sticky; cleared only at next accepted frame_start
// BEHAVIOUR
//  Reset: IDLE; all outputs 0, incl. arvalid, rready, out_valid, err. Mid-frame reset aborts at once (slave reset with us).
//  Tiles: NX = frame_width/BLOCK_W, NY = frame_height/BLOCK_H (floor); partial edge tiles skipped.
//  NX==0 or NY==0: no AR issued; IDLE->WAIT_DONE, frame_done on consumer_done.
//  araddr = base + ((tr*BLOCK_H + ln)*frame_width + tc*BLOCK_W)*BPP, modulo 2^ADDR_WIDTH.
//   Multiplies registered during prior burst; next address ready when rlast accepted.
//  FSM: IDLE -frame_start-> ADDR (arvalid=1, held stable until arready) -> DATA.
//   DATA: beat accepted on rvalid&rready; on last expected beat -> ADDR, or WAIT_DONE after tile (NY-1,NX-1) line BLOCK_H-1.
//   WAIT_DONE -consumer_done-> IDLE with frame_done=1. frame_start outside IDLE ignored.
//  One burst outstanding max; next arvalid the cycle after last beat accepted.
//  Output: 2-entry skid buffer; out_* registered, 1-cycle latency R beat -> out_valid.
//   rready = skid buffer not full; full throughput at out_ready=1; out_* stable while out_valid&!out_ready.
//  Markers per beat: sob = tile line 0 beat 0; eob = line BLOCK_H-1 beat BLOCK_W-1; sof/eof = first/last tile.
//  Errors set err, stream continues: rresp!=0; rlast early (burst closes, rest zero-filled out); rlast missing on beat BLOCK_W-1 (burst treated as closed).
//  Counters: beat log2(BLOCK_W), line log2(BLOCK_H), tc/tr 16 bits; all wrap to 0 at frame end.
// CONFIGURATION
//  BRAR_PINGPONG_EN defined: adds base_addr_alt in ADDR_WIDTH and buf_sel out 1 (reset 0).
//   Frame uses base_addr if buf_sel==0, else base_addr_alt; buf_sel toggles at each frame_done.
//  Undefined: ports absent, base_addr always used.
// TESTING
//  16x16, base 0x1000, BLOCK 8x8, out_ready=1 -> 32 bursts; tile(0,1) line0 araddr 0x1020, tile(1,0) line0 0x1200; 256 pixels, sof once, 4 sob/eob, eof on pixel 256.
//  Same frame, out_ready random 50% -> no pixel lost/duplicated; data stable during stall; rready=0 when skid full.
//  frame_width=20, height=8 -> NX=2; 16 bursts; line1 of tile(0,0) araddr = base+80.
//  frame_width=4 -> no arvalid; frame_done one cycle after consumer_done.
//  rresp=2'b10 on beat 3 of burst 5 -> err=1 through end of frame; 256 pixels; err=0 after next frame_start.
//  rst_n low mid-DATA -> next cycle arvalid=rready=out_valid=busy=0; new frame reads from tile (0,0).
//  BRAR_PINGPONG_EN, base 0x0/alt 0x8000, 3 frames -> first araddr 0x0, 0x8000, 0x0.

Source files
------------

// File: rtl/block_raster_axi_reader_if.sv
// AXI4 read-channel bundle (AR + R) between the block raster reader and its memory slave.
interface block_raster_axi_reader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic [1:0]            rresp;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rlast, rresp
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rlast, rresp
    );
endinterface

// File: rtl/block_raster_axi_reader.sv
// AXI4 read master streaming a frame tile by tile (one INCR burst per tile line, raster order).
// Optional BRAR_PINGPONG_EN: alternates frame base between i_base_addr and i_base_addr_alt.
module block_raster_axi_reader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_W    = 8,
    parameter int BLOCK_H    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           i_frame_width,
    input  logic [15:0]           i_frame_height,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
`ifdef BRAR_PINGPONG_EN
    input  logic [ADDR_WIDTH-1:0] i_base_addr_alt,
    output logic                  o_buf_sel,
`endif
    input  logic                  i_frame_start,
    input  logic                  i_consumer_done,
    block_raster_axi_reader_if.master io_axi,
    input  logic                  i_out_ready,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_sof,
    output logic                  o_out_sob,
    output logic                  o_out_eob,
    output logic                  o_out_eof,
    output logic [15:0]           o_blk_row,
    output logic [15:0]           o_blk_col,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_err
);

    localparam int BPP     = DATA_WIDTH / 8;
    localparam int BPP_LOG = $clog2(BPP);
    localparam int BW_W    = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int BH_W    = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

    localparam logic [BW_W-1:0] LAST_BEAT = BW_W'(BLOCK_W - 1);
    localparam logic [BH_W-1:0] LAST_LINE = BH_W'(BLOCK_H - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StWaitDone} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sof;
        logic                  sob;
        logic                  eob;
        logic                  eof;
        logic [15:0]           row;
        logic [15:0]           col;
    } pix_t;

    state_e                r_state;
    state_e                w_state_nxt;

    logic [15:0]           r_fw;
    logic [15:0]           r_nx;
    logic [15:0]           r_ny;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [ADDR_WIDTH-1:0] r_row_prod;
    logic [ADDR_WIDTH-1:0] r_col_off;
    logic [15:0]           r_tr;
    logic [15:0]           r_tc;
    logic [BH_W-1:0]       r_ln;
    logic [BW_W-1:0]       r_beat;
    logic                  r_fill;
    logic                  r_err;
    logic                  r_frame_done;

    pix_t                  r_out;
    logic                  r_out_valid;
    pix_t                  r_skid;
    logic                  r_skid_valid;

    logic [ADDR_WIDTH-1:0] w_base_sel;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [15:0]           w_nx_calc;
    logic [15:0]           w_ny_calc;
    logic                  w_start;
    logic                  w_ln_last;
    logic                  w_tc_last;
    logic                  w_tr_last;
    logic                  w_frame_last;
    logic [BH_W-1:0]       w_nx_ln;
    logic [15:0]           w_nx_tc;
    logic [15:0]           w_nx_tr;
    logic                  w_full;
    logic                  w_rready;
    logic                  w_bus_beat;
    logic                  w_fill_beat;
    logic                  w_beat;
    logic                  w_beat_last;
    logic                  w_early;
    logic                  w_nolast;
    logic                  w_resp_err;
    logic                  w_pop;
    pix_t                  w_pix;

`ifdef BRAR_PINGPONG_EN
    logic                  r_buf_sel;
    assign w_base_sel = r_buf_sel ? i_base_addr_alt : i_base_addr;
    assign o_buf_sel  = r_buf_sel;
`else
    assign w_base_sel = i_base_addr;
`endif

    assign w_start   = (r_state == StIdle) && i_frame_start;
    assign w_nx_calc = i_frame_width / 16'(BLOCK_W);
    assign w_ny_calc = i_frame_height / 16'(BLOCK_H);

    // Position of the burst currently in flight and the one after it
    assign w_ln_last    = (r_ln == LAST_LINE);
    assign w_tc_last    = (r_tc == 16'(r_nx - 16'd1));
    assign w_tr_last    = (r_tr == 16'(r_ny - 16'd1));
    assign w_frame_last = w_ln_last && w_tc_last && w_tr_last;

    always_comb begin
        w_nx_ln = r_ln;
        w_nx_tc = r_tc;
        w_nx_tr = r_tr;
        if (w_ln_last) begin
            w_nx_ln = '0;
            if (w_tc_last) begin
                w_nx_tc = '0;
                w_nx_tr = w_tr_last ? 16'd0 : 16'(r_tr + 16'd1);
            end else begin
                w_nx_tc = 16'(r_tc + 16'd1);
            end
        end else begin
            w_nx_ln = BH_W'(r_ln + 1'b1);
        end
    end

    // Coordinates are constant for a whole burst, so the products settle before its last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_prod <= '0;
            r_col_off  <= '0;
        end else begin
            r_row_prod <= (ADDR_WIDTH'(w_nx_tr) * ADDR_WIDTH'(BLOCK_H) + ADDR_WIDTH'(w_nx_ln))
                          * ADDR_WIDTH'(r_fw);
            r_col_off  <= ADDR_WIDTH'(w_nx_tc) * ADDR_WIDTH'(BLOCK_W);
        end
    end

    assign w_next_addr = r_base + ((r_row_prod + r_col_off) << BPP_LOG);

    // Beat acceptance; after an early rlast the remainder of the burst is zero-filled locally
    assign w_full      = r_out_valid && r_skid_valid;
    assign w_rready    = (r_state == StData) && !w_full && !r_fill;
    assign w_bus_beat  = w_rready && io_axi.rvalid;
    assign w_fill_beat = (r_state == StData) && !w_full && r_fill;
    assign w_beat      = w_bus_beat || w_fill_beat;
    assign w_beat_last = (r_beat == LAST_BEAT);
    assign w_early     = w_bus_beat && io_axi.rlast && !w_beat_last;
    assign w_nolast    = w_bus_beat && !io_axi.rlast && w_beat_last;
    assign w_resp_err  = w_bus_beat && (io_axi.rresp != 2'b00);

    always_comb begin
        w_pix      = '0;
        w_pix.data = r_fill ? '0 : io_axi.rdata;
        w_pix.sob  = (r_ln == '0) && (r_beat == '0);
        w_pix.eob  = w_ln_last && w_beat_last;
        w_pix.sof  = w_pix.sob && (r_tr == 16'd0) && (r_tc == 16'd0);
        w_pix.eof  = w_pix.eob && w_tc_last && w_tr_last;
        w_pix.row  = r_tr;
        w_pix.col  = r_tc;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_frame_start) begin
                    w_state_nxt = (w_nx_calc == 16'd0 || w_ny_calc == 16'd0) ? StWaitDone
                                                                             : StAddr;
                end
            end
            StAddr: begin
                if (io_axi.arready) w_state_nxt = StData;
            end
            StData: begin
                if (w_beat && w_beat_last) w_state_nxt = w_frame_last ? StWaitDone : StAddr;
            end
            StWaitDone: begin
                if (i_consumer_done) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fw         <= '0;
            r_nx         <= '0;
            r_ny         <= '0;
            r_base       <= '0;
            r_araddr     <= '0;
            r_tr         <= '0;
            r_tc         <= '0;
            r_ln         <= '0;
            r_beat       <= '0;
            r_fill       <= 1'b0;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (r_state == StWaitDone) && i_consumer_done;
            if (w_start) begin
                r_fw     <= i_frame_width;
                r_nx     <= w_nx_calc;
                r_ny     <= w_ny_calc;
                r_base   <= w_base_sel;
                r_araddr <= w_base_sel;
                r_tr     <= '0;
                r_tc     <= '0;
                r_ln     <= '0;
                r_beat   <= '0;
                r_fill   <= 1'b0;
                r_err    <= 1'b0;
            end else if (w_beat) begin
                if (w_early || w_nolast || w_resp_err) r_err <= 1'b1;
                if (w_beat_last) begin
                    r_beat   <= '0;
                    r_fill   <= 1'b0;
                    r_ln     <= w_nx_ln;
                    r_tc     <= w_nx_tc;
                    r_tr     <= w_nx_tr;
                    r_araddr <= w_next_addr;
                end else begin
                    r_beat <= BW_W'(r_beat + 1'b1);
                    if (w_early) r_fill <= 1'b1;
                end
            end
        end
    end

`ifdef BRAR_PINGPONG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_sel <= 1'b0;
        end else if ((r_state == StWaitDone) && i_consumer_done) begin
            r_buf_sel <= !r_buf_sel;
        end
    end
`endif

    // Two-entry skid: r_out drives the port, r_skid catches the beat accepted during a stall
    assign w_pop = r_out_valid && i_out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_pop || !r_out_valid) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= w_beat;
                if (w_beat) r_skid <= w_pix;
            end else begin
                r_out_valid <= w_beat;
                if (w_beat) r_out <= w_pix;
            end
        end else if (w_beat) begin
            r_skid       <= w_pix;
            r_skid_valid <= 1'b1;
        end
    end

    assign io_axi.arvalid = (r_state == StAddr);
    assign io_axi.araddr  = r_araddr;
    assign io_axi.arlen   = 8'(BLOCK_W - 1);
    assign io_axi.arsize  = 3'(BPP_LOG);
    assign io_axi.arburst = 2'b01;
    assign io_axi.rready  = w_rready;

    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out.data;
    assign o_out_sof    = r_out.sof;
    assign o_out_sob    = r_out.sob;
    assign o_out_eob    = r_out.eob;
    assign o_out_eof    = r_out.eof;
    assign o_blk_row    = r_out.row;
    assign o_blk_col    = r_out.col;
    assign o_busy       = (r_state != StIdle);
    assign o_frame_done = r_frame_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_block_raster_axi_reader.sv
// Scoreboard bench for block_raster_axi_reader: AXI slave model, expected AR/pixel queues, stream monitor.
module tb_block_raster_axi_reader;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int BH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] fw, fh;
    logic [31:0] base;
    logic        frame_start, consumer_done, out_ready;
    logic        out_valid, sof, sob, eob, eof, busy, frame_done, err;
    logic [31:0] out_data;
    logic [15:0] blk_row, blk_col;
`ifdef BRAR_PINGPONG_EN
    logic [31:0] base_alt;
    logic        buf_sel;
`endif

    always #5 clk = ~clk;

    block_raster_axi_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_axi ();

    block_raster_axi_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_W(BW), .BLOCK_H(BH)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_frame_width   (fw),
        .i_frame_height  (fh),
        .i_base_addr     (base),
`ifdef BRAR_PINGPONG_EN
        .i_base_addr_alt (base_alt),
        .o_buf_sel       (buf_sel),
`endif
        .i_frame_start   (frame_start),
        .i_consumer_done (consumer_done),
        .io_axi          (u_axi),
        .i_out_ready     (out_ready),
        .o_out_valid     (out_valid),
        .o_out_data      (out_data),
        .o_out_sof       (sof),
        .o_out_sob       (sob),
        .o_out_eob       (eob),
        .o_out_eof       (eof),
        .o_blk_row       (blk_row),
        .o_blk_col       (blk_col),
        .o_busy          (busy),
        .o_frame_done    (frame_done),
        .o_err           (err)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  flags;  // sof, sob, eob, eof
        logic [15:0] row;
        logic [15:0] col;
    } pix_t;

    int          n_checks = 0;
    int          n_errors = 0;
    pix_t        pix_q[$];
    logic [31:0] ar_exp_q[$];
    logic [31:0] ar_log[$];
    int          pix_cnt, sof_cnt, sob_cnt, eob_cnt, eof_cnt;
    int          beats_in = 0;
    int          s_burst = 0;
    int          err_burst = -1;
    int          err_beat = -1;
    bit          rand_mode = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [127:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got 0x%0h expected none", name, act);
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h0001_9E37) ^ 32'hC0DE_0000;
    endfunction

    // Slave: decide handshakes at negedge (inputs are stable until the next posedge), drive at posedge+1
    initial begin
        logic        ar_f, r_f;
        logic [31:0] ar_a;
        logic [31:0] s_addr;
        bit          s_busy;
        int          s_beat;
        u_axi.arready = 1'b0;
        u_axi.rvalid  = 1'b0;
        u_axi.rdata   = '0;
        u_axi.rlast   = 1'b0;
        u_axi.rresp   = 2'b00;
        s_busy = 1'b0;
        s_beat = 0;
        s_addr = '0;
        forever begin
            @(negedge clk);
            ar_f = u_axi.arvalid && u_axi.arready;
            r_f  = u_axi.rvalid && u_axi.rready;
            ar_a = u_axi.araddr;
            if (ar_f) begin
                ar_log.push_back(ar_a);
                if (ar_exp_q.size() == 0) fail("unexpected_ar", ar_a);
                else check("araddr", ar_a, ar_exp_q.pop_front());
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s_busy = 1'b0;
                beats_in = 0;
                u_axi.arready = 1'b0;
                u_axi.rvalid = 1'b0;
                u_axi.rlast = 1'b0;
                u_axi.rresp = 2'b00;
                continue;
            end
            if (ar_f) begin
                s_busy = 1'b1;
                s_addr = ar_a;
                s_beat = 0;
            end
            if (r_f) begin
                beats_in++;
                s_beat++;
                if (s_beat == BW) begin
                    s_busy = 1'b0;
                    s_burst++;
                end
            end
            if (!s_busy) begin
                u_axi.rvalid = 1'b0;
                u_axi.rlast  = 1'b0;
                u_axi.rresp  = 2'b00;
            end else if (!(u_axi.rvalid && !r_f)) begin
                u_axi.rvalid = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
                u_axi.rdata  = mem_fn(s_addr + 32'(4 * s_beat));
                u_axi.rlast  = (s_beat == BW - 1);
                u_axi.rresp  = (s_burst == err_burst && s_beat == err_beat) ? 2'b10 : 2'b00;
            end
            u_axi.arready = !s_busy;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Stream monitor: pops the scoreboard on each accepted pixel, checks stall stability and skid fill
    initial begin
        pix_t got, held;
        bit   stalled = 1'b0;
        int   pops_done = 0;
        int   pending_pop = 0;
        int   occ;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
                pops_done = 0;
                pending_pop = 0;
                continue;
            end
            pops_done += pending_pop;
            pending_pop = 0;
            got = {out_data, sof, sob, eob, eof, blk_row, blk_col};
            if (stalled) check("stall_stable", {out_valid, got}, {1'b1, held});
            stalled = out_valid && !out_ready;
            held = got;
            occ = beats_in - pops_done;
            if (occ >= 2) check("rready_when_full", {occ > 2, u_axi.rready}, 2'b00);
            if (out_valid && out_ready) begin
                pending_pop = 1;
                pix_cnt++;
                sof_cnt += int'(sof);
                sob_cnt += int'(sob);
                eob_cnt += int'(eob);
                eof_cnt += int'(eof);
                if (pix_q.size() == 0) fail("unexpected_pixel", got);
                else check("pixel", got, pix_q.pop_front());
            end
        end
    end

    task automatic load_expect(input int w, input int h, input logic [31:0] eb);
        int nx, ny;
        logic [31:0] a;
        pix_t p;
        nx = w / BW;
        ny = h / BH;
        for (int tr = 0; tr < ny; tr++)
            for (int tc = 0; tc < nx; tc++)
                for (int ln = 0; ln < BH; ln++) begin
                    a = eb + 32'(((tr * BH + ln) * w + tc * BW) * 4);
                    ar_exp_q.push_back(a);
                    for (int b = 0; b < BW; b++) begin
                        p.data  = mem_fn(a + 32'(4 * b));
                        p.flags = {tr == 0 && tc == 0 && ln == 0 && b == 0,
                                   ln == 0 && b == 0,
                                   ln == BH - 1 && b == BW - 1,
                                   tr == ny - 1 && tc == nx - 1 && ln == BH - 1 && b == BW - 1};
                        p.row = 16'(tr);
                        p.col = 16'(tc);
                        pix_q.push_back(p);
                    end
                end
    endtask

    task automatic start_frame(input int w, input int h, input logic [31:0] eb, input int e_burst,
                               input int e_beat);
        ar_log.delete();
        pix_cnt = 0;
        sof_cnt = 0;
        sob_cnt = 0;
        eob_cnt = 0;
        eof_cnt = 0;
        s_burst = 0;
        err_burst = e_burst;
        err_beat = e_beat;
        load_expect(w, h, eb);
        fw = 16'(w);
        fh = 16'(h);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, 1'b1);
        check("err_cleared_at_start", err, 1'b0);
    endtask

    task automatic run_frame(input int w, input int h, input logic [31:0] eb, input int e_burst,
                             input int e_beat);
        int cyc = 0;
        start_frame(w, h, eb, e_burst, e_beat);
        while ((pix_q.size() != 0 || ar_exp_q.size() != 0) && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 6000) fail("frame_timeout", pix_q.size());
        repeat (4) @(negedge clk);
        check("frame_bursts", ar_log.size(), (w / BW) * (h / BH) * BH);
        check("frame_pixels", pix_cnt, (w / BW) * (h / BH) * BW * BH);
        check("busy_in_wait_done", busy, 1'b1);
        check("no_done_before_consumer", frame_done, 1'b0);
        @(posedge clk);
        #1;
        consumer_done = 1'b1;
        @(posedge clk);
        #1;
        consumer_done = 1'b0;
        @(negedge clk);
        check("frame_done_pulse", {frame_done, busy}, 2'b10);
        @(negedge clk);
        check("frame_done_one_cycle", frame_done, 1'b0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        fw = '0;
        fh = '0;
        base = 32'h1000;
`ifdef BRAR_PINGPONG_EN
        base_alt = 32'h1000;
`endif
        frame_start = 1'b0;
        consumer_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {u_axi.arvalid, u_axi.rready, out_valid, busy, err, frame_done},
              6'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 16x16 frame, free-flowing output
        run_frame(16, 16, 32'h1000, -1, -1);
        check("t1_bursts", ar_log.size(), 32);
        check("t1_ar_tile01", ar_log[8], 32'h1020);
        check("t1_ar_tile10", ar_log[16], 32'h1200);
        check("t1_pixels", pix_cnt, 256);
        check("t1_sof_count", sof_cnt, 1);
        check("t1_sob_count", sob_cnt, 4);
        check("t1_eob_count", eob_cnt, 4);
        check("t1_eof_count", eof_cnt, 1);

        // Same frame under random backpressure and R gaps
        rand_mode = 1'b1;
        run_frame(16, 16, 32'h1000, -1, -1);
        rand_mode = 1'b0;
        check("t2_pixels", pix_cnt, 256);

        // Partial right tile skipped: NX = 2
        run_frame(20, 8, 32'h1000, -1, -1);
        check("t3_bursts", ar_log.size(), 16);
        check("t3_ar_line1", ar_log[1], 32'h1050);

        // No full tile: straight to WAIT_DONE
        run_frame(4, 16, 32'h1000, -1, -1);
        check("t4_no_ar", ar_log.size(), 0);

        // Error response mid-frame: sticky err, stream intact
        run_frame(16, 16, 32'h1000, 5, 3);
        check("t5_pixels", pix_cnt, 256);
        check("t5_err_sticky", err, 1'b1);
        run_frame(16, 16, 32'h1000, -1, -1);
        check("t5_err_stays_clear", err, 1'b0);

        // Reset in the middle of a frame
        start_frame(16, 16, 32'h1000, -1, -1);
        cyc = 0;
        while (ar_log.size() < 3 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 1000) fail("t6_wait_ar", ar_log.size());
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_reset_abort", {u_axi.arvalid, u_axi.rready, out_valid, busy}, 4'b0);
        pix_q.delete();
        ar_exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(16, 16, 32'h1000, -1, -1);
        check("t6_restart_tile00", ar_log[0], 32'h1000);

`ifdef BRAR_PINGPONG_EN
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("pp_reset_sel", buf_sel, 1'b0);
        base = 32'h0;
        base_alt = 32'h8000;
        run_frame(8, 8, 32'h0, -1, -1);
        check("pp_frame0", ar_log[0], 32'h0);
        check("pp_sel_toggle", buf_sel, 1'b1);
        run_frame(8, 8, 32'h8000, -1, -1);
        check("pp_frame1", ar_log[0], 32'h8000);
        run_frame(8, 8, 32'h0, -1, -1);
        check("pp_frame2", ar_log[0], 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
